input_conditioner: RTL and testbench

Front-end conditioning stage that sits directly upstream of the square-root finder and display path. It synchronises and debounces the raw start push-button and the 8 data slide switches, produces a clean level and a single-cycle start pulse, and latches the operand under a req/ack handshake so the finder sees exactly one request per physical press. The live debounced switch value is also exported for the display mux while no request is pending.

---
 rtl/input_conditioner.sv | 138 +++++++++++++
 tb/tb_input_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : input_conditioner
//  Purpose  : Synchronises and debounces the start button and switch bus,
//             emits a single start pulse per accepted press, and latches the
//             operand under an op_req/op_ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              btn_start,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              op_ack,
  output logic              start_level,
  output logic              start_pulse,
  output logic [DATA_W-1:0] data_live,
  output logic [DATA_W-1:0] operand,
  output logic              op_req,
  output logic [3:0]        dropped_cnt
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  // The counter qualifies on the edge it would otherwise reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Button path state
  logic             btn_sync1;
  logic             btn_s;
  logic             btn_s_prev;
  logic [CNT_W-1:0] btn_cnt;
  logic [CNT_W-1:0] btn_cnt_next;
  logic             btn_deb_next;

  // Switch bus path state (one counter shared by every bit)
  logic [DATA_W-1:0] sw_sync1;
  logic [DATA_W-1:0] sw_s;
  logic [DATA_W-1:0] sw_s_prev;
  logic [CNT_W-1:0]  sw_cnt;
  logic [CNT_W-1:0]  sw_cnt_next;
  logic [DATA_W-1:0] sw_deb_next;

  // Handshake decode
  logic press;
  logic req_kept;

  // Two-flop synchronisers plus the one-cycle-old copy used for change detection
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      btn_sync1  <= 1'b0;
      btn_s      <= 1'b0;
      btn_s_prev <= 1'b0;
      sw_sync1   <= '0;
      sw_s       <= '0;
      sw_s_prev  <= '0;
    end else begin
      btn_sync1  <= btn_start;
      btn_s      <= btn_sync1;
      btn_s_prev <= btn_s;
      sw_sync1   <= sw_data;
      sw_s       <= sw_sync1;
      sw_s_prev  <= sw_s;
    end
  end

  // Button qualification: count stable cycles that disagree with the debounced level
  always_comb begin
    btn_cnt_next = btn_cnt + CNT_ONE;
    btn_deb_next = start_level;
    if ((btn_s != btn_s_prev) || (btn_s == start_level)) begin
      btn_cnt_next = '0;
    end else if (btn_cnt == CNT_LAST) begin
      btn_cnt_next = '0;
      btn_deb_next = btn_s;
    end
  end

  // Switch qualification: any bit change restarts the whole bus
  always_comb begin
    sw_cnt_next = sw_cnt + CNT_ONE;
    sw_deb_next = data_live;
    if ((sw_s != sw_s_prev) || (sw_s == data_live)) begin
      sw_cnt_next = '0;
    end else if (sw_cnt == CNT_LAST) begin
      sw_cnt_next = '0;
      sw_deb_next = sw_s;
    end
  end

  // Debounce counters and debounced values
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      btn_cnt     <= '0;
      start_level <= 1'b0;
      sw_cnt      <= '0;
      data_live   <= '0;
    end else begin
      btn_cnt     <= btn_cnt_next;
      start_level <= btn_deb_next;
      sw_cnt      <= sw_cnt_next;
      data_live   <= sw_deb_next;
    end
  end

  // A press is the debounced level rising on this edge; an ack on the same
  // edge frees the request slot before the press is judged.
  assign press    = btn_deb_next & ~start_level;
  assign req_kept = op_req & ~op_ack;

  // Request handshake, operand capture and rejected-press counter
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      start_pulse <= 1'b0;
      operand     <= '0;
      op_req      <= 1'b0;
      dropped_cnt <= 4'd0;
    end else begin
      start_pulse <= 1'b0;
      if (press && !req_kept) begin
        start_pulse <= 1'b1;
        operand     <= data_live;
        op_req      <= 1'b1;
      end else begin
        op_req <= req_kept;
        if (press && (dropped_cnt != 4'hF)) begin
          dropped_cnt <= dropped_cnt + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_input_conditioner
//  Purpose  : Randomised and directed bench for input_conditioner with a
//             window-based reference model and an operand scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         btn_start = 1'b0;
  logic [W-1:0] sw_data = '0;
  logic         op_ack = 1'b0;
  logic         start_level;
  logic         start_pulse;
  logic [W-1:0] data_live;
  logic [W-1:0] operand;
  logic         op_req;
  logic [3:0]   dropped_cnt;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .DATA_W(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .btn_start   (btn_start),
    .sw_data     (sw_data),
    .op_ack      (op_ack),
    .start_level (start_level),
    .start_pulse (start_pulse),
    .data_live   (data_live),
    .operand     (operand),
    .op_req      (op_req),
    .dropped_cnt (dropped_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a debounced value adopts v when the last D+1 values seen
  // by the synchroniser's output (raw samples delayed by two edges) all equal v.
  logic         hist_b[$];
  logic [W-1:0] hist_s[$];
  logic [W-1:0] exp_q[$];
  logic         m_lvl, m_pulse, m_req;
  logic [W-1:0] m_live, m_opnd;
  logic [3:0]   m_drop;

  task automatic model_reset();
    hist_b.delete();
    hist_s.delete();
    exp_q.delete();
    for (int i = 0; i < D + 3; i++) begin
      hist_b.push_back(1'b0);
      hist_s.push_back('0);
    end
    m_lvl = 0; m_pulse = 0; m_req = 0; m_live = '0; m_opnd = '0; m_drop = '0;
  endtask

  task automatic model_step();
    logic         same_b, same_s, new_lvl, press, req;
    logic [W-1:0] new_live;
    same_b = 1'b1;
    same_s = 1'b1;
    for (int i = 2; i <= D + 1; i++) begin
      if (hist_b[i] != hist_b[1]) same_b = 1'b0;
      if (hist_s[i] != hist_s[1]) same_s = 1'b0;
    end
    new_lvl  = same_b ? hist_b[1] : m_lvl;
    new_live = same_s ? hist_s[1] : m_live;
    press    = new_lvl && !m_lvl;
    req      = m_req && !op_ack;
    m_pulse  = 1'b0;
    if (press && !req) begin
      m_pulse = 1'b1;
      m_opnd  = m_live;
      req     = 1'b1;
      exp_q.push_back(m_live);
    end else if (press && m_drop != 4'hF) begin
      m_drop = m_drop + 4'd1;
    end
    m_req  = req;
    m_lvl  = new_lvl;
    m_live = new_live;
    hist_b.push_back(btn_start);
    void'(hist_b.pop_front());
    hist_s.push_back(sw_data);
    void'(hist_s.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge clr_n);
      if (!clr_n) model_reset();
      else model_step();
    end
  end

  // Monitor: compares every output against the model and pops the scoreboard on each pulse
  initial begin
    forever begin
      @(negedge clk);
      check("start_level", start_level, m_lvl);
      check("start_pulse", start_pulse, m_pulse);
      check("data_live", data_live, m_live);
      check("operand", operand, m_opnd);
      check("op_req", op_req, m_req);
      check("dropped_cnt", dropped_cnt, m_drop);
      if (start_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_pulse: got pulse with operand %0h expected no pulse", operand);
        end else begin
          check("sb_operand", operand, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int btn_hold, sw_hold;
    // Reset with button held and switches at A5, then an asynchronous reset mid-cycle
    clr_n = 1'b0; btn_start = 1'b1; sw_data = 8'hA5;
    cyc(3);
    clr_n = 1'b1;
    cyc(12);
    #2 clr_n = 1'b0;
    #1;
    check("rst_start_level", start_level, 0);
    check("rst_start_pulse", start_pulse, 0);
    check("rst_data_live", data_live, 0);
    check("rst_operand", operand, 0);
    check("rst_op_req", op_req, 0);
    check("rst_dropped_cnt", dropped_cnt, 0);
    cyc(2);
    clr_n = 1'b1;
    cyc(6);
    check("lat_pre_level", start_level, 0);
    check("lat_pre_live", data_live, 0);
    cyc(1);
    check("lat_level", start_level, 1);
    check("lat_live", data_live, 8'hA5);
    check("lat_pulse", start_pulse, 1);
    check("lat_req", op_req, 1);
    op_ack = 1'b1; cyc(1); op_ack = 1'b0;

    // Clean press with operand 81, ack at k+9
    btn_start = 1'b0; sw_data = 8'd81;
    cyc(10);
    btn_start = 1'b1;
    cyc(7);
    check("press_pulse", start_pulse, 1);
    check("press_operand", operand, 81);
    check("press_req", op_req, 1);
    cyc(1);
    check("press_pulse_one", start_pulse, 0);
    cyc(1);
    op_ack = 1'b1;
    cyc(1);
    op_ack = 1'b0;
    check("ack_req_low", op_req, 0);

    // Button glitches and a fast-toggling switch bit
    btn_start = 1'b0;
    cyc(10);
    for (int i = 0; i < 3; i++) begin
      btn_start = 1'b1; cyc(3);
      btn_start = 1'b0; cyc(3);
    end
    for (int i = 0; i < 10; i++) begin
      sw_data = 8'd81 ^ 8'h08; cyc(2);
      sw_data = 8'd81;         cyc(2);
    end
    cyc(8);
    check("glitch_level", start_level, 0);
    check("glitch_req", op_req, 0);
    check("glitch_live", data_live, 81);

    // Press accepted with 0x10, then 17 presses while pending
    sw_data = 8'h10;
    cyc(10);
    btn_start = 1'b1; cyc(8);
    btn_start = 1'b0; cyc(8);
    sw_data = 8'h20;
    cyc(10);
    for (int i = 0; i < 17; i++) begin
      btn_start = 1'b1; cyc(7);
      btn_start = 1'b0; cyc(7);
    end
    check("pend_operand", operand, 8'h10);
    check("pend_dropped", dropped_cnt, 15);
    check("pend_req", op_req, 1);

    // Ack sampled on the same edge a new press qualifies
    sw_data = 8'd144;
    cyc(10);
    btn_start = 1'b1;
    cyc(6);
    op_ack = 1'b1;
    cyc(1);
    op_ack = 1'b0;
    check("sim_pulse", start_pulse, 1);
    check("sim_req", op_req, 1);
    check("sim_operand", operand, 144);
    check("sim_dropped", dropped_cnt, 15);
    btn_start = 1'b0;
    cyc(10);

    // Switch change during qualification
    sw_data = 8'h01;
    cyc(12);
    sw_data = 8'h03; cyc(2);
    sw_data = 8'h07; cyc(6);
    check("swchg_old", data_live, 8'h01);
    cyc(1);
    check("swchg_new", data_live, 8'h07);
    op_ack = 1'b1; cyc(1); op_ack = 1'b0;

    // Randomised traffic
    btn_hold = 1;
    sw_hold = 1;
    for (int i = 0; i < 600; i++) begin
      if (--btn_hold == 0) begin
        btn_start = ~btn_start;
        btn_hold  = $urandom_range(1, 10);
      end
      if (--sw_hold == 0) begin
        if ($urandom_range(0, 1) == 0) sw_data = W'($urandom);
        else sw_data = sw_data ^ (W'(1) << $urandom_range(0, W - 1));
        sw_hold = $urandom_range(1, 12);
      end
      op_ack = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    op_ack = 1'b0;
    btn_start = 1'b0;
    cyc(15);
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
